// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory access open until memReady.
  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive wait cycles of a memory access; flags the last tolerated one.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TW          = 5
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [TW-1:0] Limit  = (MEM_TIMEOUT == 0) ? '0 : TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0] MaxCnt = '1;

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (waiting && (count_q != MaxCnt)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && waiting && (count_q == Limit);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory handshake and wait timeout recovery.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TW          = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instrDone,
  output logic       illegalOp,
  output logic       memTimeout
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       waiting, expired, tmr_clear;

  assign waiting   = is_mem_state(state_q) && !memReady;
  // A FETCH timeout keeps the state unchanged, so expiry must clear the timer too.
  assign tmr_clear = (state_d != state_q) || memReady || expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .clear  (tmr_clear),
    .waiting(waiting),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      RESET:  state_d = FETCH;
      FETCH:  if (memReady) state_d = DECODE;
      DECODE: begin
        op_d = opCode;
        case (opCode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (memReady) state_d = MEMWB;
              else if (expired) state_d = FETCH;
      MEMWR:  if (memReady || expired) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= RESET;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;
    memTimeout  = expired;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = memReady;
        PCWrite = memReady;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        if (!(opCode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI})) begin
          illegalOp = 1'b1;
          instrDone = 1'b1;
        end
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        instrDone = 1'b1;
      end
      MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        instrDone = memReady;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        instrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instrDone   = 1'b1;
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = PCSRC_JUMP;
        instrDone = 1'b1;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        instrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench: instruction-schedule reference model, directed steps then random opcode/memReady traffic.
module tb_mips_multicycle_ctrl;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [5:0] opCode = '0;
  logic       memReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
  logic       RegWrite, ALUSrcA, instrDone, illegalOp, memTimeout;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .TW(5)) dut (
    .clk(clk), .resetN(resetN), .opCode(opCode), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instrDone(instrDone), .illegalOp(illegalOp),
    .memTimeout(memTimeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic done, ill, tmo;
  } outs_t;

  typedef enum int {K_RESET, K_FETCH, K_DECODE, K_ADDR, K_RD, K_RDWB, K_WR, K_EXEC,
                    K_ALUWB, K_BR, K_J, K_ADDIEX, K_ADDIWB} kind_e;

  int         errors = 0;
  int         checks = 0;
  bit         m_reset_cyc = 1'b0;
  int         m_idx = 0;
  int         m_wait = 0;
  logic [5:0] m_op = '0;
  outs_t      last_obs;

  // Number of steps each instruction takes from FETCH to its final step.
  function automatic int seq_len(logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      6'b001000: return 4;
      default:   return 2;
    endcase
  endfunction

  function automatic kind_e step_of(int idx, logic [5:0] op);
    if (idx == 0) return K_FETCH;
    if (idx == 1) return K_DECODE;
    case (op)
      6'b000000: return (idx == 2) ? K_EXEC : K_ALUWB;
      6'b100011: return (idx == 2) ? K_ADDR : ((idx == 3) ? K_RD : K_RDWB);
      6'b101011: return (idx == 2) ? K_ADDR : K_WR;
      6'b000100: return K_BR;
      6'b000010: return K_J;
      default:   return (idx == 2) ? K_ADDIEX : K_ADDIWB;
    endcase
  endfunction

  function automatic outs_t expect_outs(kind_e k, logic mr, logic to, logic [5:0] op_in);
    outs_t o;
    o = '0;
    case (k)
      K_FETCH:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; o.tmo = to; end
      K_DECODE: begin
        o.srcb = 2'b11;
        if (seq_len(op_in) == 2) begin o.ill = 1; o.done = 1; end
      end
      K_ADDR, K_ADDIEX: begin o.srca = 1; o.srcb = 2'b10; end
      K_RD:     begin o.mrd = 1; o.iord = 1; o.tmo = to; end
      K_RDWB:   begin o.rw = 1; o.m2r = 1; o.done = 1; end
      K_WR:     begin o.mwr = 1; o.iord = 1; o.done = mr; o.tmo = to; end
      K_EXEC:   begin o.srca = 1; o.aluop = 2'b10; end
      K_ALUWB:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
      K_BR:     begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; o.done = 1; end
      K_J:      begin o.pcw = 1; o.pcsrc = 2'b10; o.done = 1; end
      K_ADDIWB: begin o.rw = 1; o.done = 1; end
      default:  ;
    endcase
    return o;
  endfunction

  function automatic outs_t obs_now();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instrDone, illegalOp, memTimeout};
  endfunction

  task automatic chk_zero(input string tag);
    outs_t obs;
    obs = obs_now();
    checks++;
    assert (obs === '0) else begin
      errors++;
      $error("FAIL %s observed=%h expected=0", tag, obs);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance the model.
  task automatic cyc(input logic [5:0] op, input logic mr);
    kind_e k;
    logic  to, mem;
    outs_t exp;
    @(negedge clk);
    opCode   = op;
    memReady = mr;
    #1;
    k   = m_reset_cyc ? K_RESET : step_of(m_idx, m_op);
    mem = (k == K_FETCH) || (k == K_RD) || (k == K_WR);
    to  = mem && !mr && (m_wait == TO - 1);
    exp = expect_outs(k, mr, to, op);
    last_obs = obs_now();
    checks++;
    assert (last_obs === exp) else begin
      errors++;
      $error("FAIL step=%s op=%b mr=%b observed=%h expected=%h", k.name(), op, mr, last_obs, exp);
    end
    if (m_reset_cyc) begin
      m_reset_cyc = 1'b0;
      m_idx = 0;
    end else if (k == K_DECODE) begin
      m_op  = op;
      m_idx = (seq_len(op) == 2) ? 0 : 2;
      m_wait = 0;
    end else if (mem && !mr) begin
      if (to) begin
        m_idx  = 0;
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_idx++;
      if (m_idx >= seq_len(m_op)) m_idx = 0;
      m_wait = 0;
    end
  endtask

  // Asynchronous reset pulse held across a clock edge, released mid-cycle.
  task automatic do_reset();
    #2;
    resetN   = 1'b0;
    memReady = 1'b1;
    #1;
    chk_zero("reset_async");
    @(posedge clk);
    #1;
    chk_zero("reset_held");
    resetN = 1'b1;
    #1;
    chk_zero("reset_released");
    m_reset_cyc = 1'b1;
    m_idx  = 0;
    m_wait = 0;
  endtask

  // Run one instruction with memReady=1, checking cycle count up to instrDone.
  task automatic run_lat(input logic [5:0] op, input int exp_lat);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(op, 1'b1);
      n++;
      if (last_obs.done) break;
    end
    checks++;
    assert (n == exp_lat) else begin
      errors++;
      $error("FAIL latency op=%b observed=%0d expected=%0d", op, n, exp_lat);
    end
  endtask

  initial begin
    int n, stall;
    logic [5:0] op;
    logic mr;
    memReady = 1'b1;
    #7;
    chk_zero("reset_initial");
    #3;
    resetN = 1'b1;
    #1;
    chk_zero("first_cycle_after_reset");

    run_lat(6'b000000, 4);
    run_lat(6'b100011, 5);
    run_lat(6'b101011, 4);
    run_lat(6'b000100, 3);
    run_lat(6'b000010, 3);
    run_lat(6'b001000, 4);
    run_lat(6'b011001, 2);

    // lw with three wait cycles in the read phase
    cyc(6'b100011, 1'b1);
    cyc(6'b100011, 1'b1);
    cyc(6'b111111, 1'b1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(6'b000000, (i == 3));
      if (last_obs.mrd && last_obs.iord && !last_obs.tmo) n++;
    end
    checks++;
    assert (n == 4) else begin
      errors++;
      $error("FAIL lw_stall_read_cycles observed=%0d expected=4", n);
    end
    cyc(6'b000000, 1'b1);

    // sw with a memory that never answers
    cyc(6'b000000, 1'b1);
    cyc(6'b101011, 1'b1);
    cyc(6'b101011, 1'b1);
    n = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(6'($urandom), 1'b0);
      n++;
      if (last_obs.tmo) break;
    end
    checks++;
    assert (n == 16 && last_obs.done === 1'b0) else begin
      errors++;
      $error("FAIL sw_timeout observed=%0d/done=%b expected=16/0", n, last_obs.done);
    end
    cyc(6'b000010, 1'b1);
    cyc(6'b000010, 1'b1);
    cyc(6'b000010, 1'b1);

    // FETCH timeout then recovery
    for (int i = 0; i < 18; i++) cyc(6'b000000, 1'b0);
    run_lat(6'b000100, 3);

    // Reset in the middle of a store wait
    cyc(6'b101011, 1'b1);
    cyc(6'b101011, 1'b1);
    cyc(6'b101011, 1'b1);
    cyc(6'b101011, 1'b0);
    cyc(6'b101011, 1'b0);
    do_reset();

    stall = 0;
    for (int i = 0; i < 2500; i++) begin
      n  = int'($urandom_range(0, 7));
      op = (n == 0) ? 6'b000000 : (n == 1) ? 6'b100011 : (n == 2) ? 6'b101011 :
           (n == 3) ? 6'b000100 : (n == 4) ? 6'b000010 : (n == 5) ? 6'b001000 :
           6'($urandom);
      if (stall > 0) begin
        mr = 1'b0;
        stall--;
      end else begin
        if ($urandom_range(0, 39) == 0) stall = int'($urandom_range(10, 24));
        mr = ($urandom_range(0, 3) != 0);
      end
      cyc(op, mr);
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
